// File: rtl/arb_pkg.sv
// Shared constants and state type for the 8-way round-robin arbiter.
package arb_pkg;

  localparam int N_REQ = 8;
  localparam int IDX_W = 3;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// Masked priority encoder: finds the first set request at or after ptr,
// wrapping mod 8. Purely combinational.
module rr_pick
  import arb_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  logic [2*N_REQ-1:0] dbl;
  logic [N_REQ-1:0]   rot;
  logic [IDX_W-1:0]   off;

  // Rotate so that bit ptr lands at position 0.
  always_comb begin
    dbl = {req, req} >> ptr;
    rot = dbl[N_REQ-1:0];
  end

  // Lowest set bit of the rotated vector, then undo the rotation.
  always_comb begin
    off = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (rot[i]) off = IDX_W'(i);
    end
    idx = off + ptr;
    any = |req;
  end

endmodule

// File: rtl/rr_arbiter_8.sv
// Round-robin arbiter for 8 requesters. A grant is held until the owner
// drops its request or MAX_HOLD cycles elapse; every grant is followed by
// one dead cycle in which the next winner is chosen.
module rr_arbiter_8
  import arb_pkg::*;
#(
  parameter int MAX_HOLD = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] gnt,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             gnt_valid
);

  localparam int HC_W = (MAX_HOLD == 0) ? 1 : $clog2(MAX_HOLD + 1);
  localparam logic [HC_W-1:0] HOLD_LAST = HC_W'((MAX_HOLD == 0) ? 0 : MAX_HOLD - 1);
  localparam bit TIMEOUT_EN = (MAX_HOLD != 0);

  arb_state_t       state, state_n;
  logic [IDX_W-1:0] ptr, ptr_n;
  logic [HC_W-1:0]  hold_cnt, hold_cnt_n;
  logic [N_REQ-1:0] gnt_n;
  logic [IDX_W-1:0] gnt_idx_n;
  logic             gnt_valid_n;

  logic [IDX_W-1:0] pick_idx;
  logic             pick_any;
  logic             release_evt;
  logic             timeout_evt;

  // Counter stops at all-ones; only reachable when the timeout is disabled.
  function automatic logic [HC_W-1:0] sat_inc(input logic [HC_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

  rr_pick u_pick (
    .req (req),
    .ptr (ptr),
    .idx (pick_idx),
    .any (pick_any)
  );

  // Release and timeout on the same edge produce the same result, so
  // they are simply OR-ed together in the next-state logic.
  always_comb begin
    release_evt = ~req[gnt_idx];
    timeout_evt = TIMEOUT_EN && (hold_cnt == HOLD_LAST);
  end

  // Next-state and next-output logic; defaults hold every register.
  always_comb begin
    state_n     = state;
    ptr_n       = ptr;
    hold_cnt_n  = hold_cnt;
    gnt_n       = gnt;
    gnt_idx_n   = gnt_idx;
    gnt_valid_n = gnt_valid;
    case (state)
      IDLE: begin
        if (pick_any) begin
          state_n     = GRANT;
          gnt_n       = N_REQ'(1) << pick_idx;
          gnt_idx_n   = pick_idx;
          gnt_valid_n = 1'b1;
          ptr_n       = pick_idx + IDX_W'(1);
          hold_cnt_n  = '0;
        end
      end
      GRANT: begin
        if (release_evt || timeout_evt) begin
          state_n     = IDLE;
          gnt_n       = '0;
          gnt_idx_n   = '0;
          gnt_valid_n = 1'b0;
        end else begin
          hold_cnt_n  = sat_inc(hold_cnt);
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // State and output registers; reset overrides every other event.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      ptr       <= '0;
      hold_cnt  <= '0;
      gnt       <= '0;
      gnt_idx   <= '0;
      gnt_valid <= 1'b0;
    end else begin
      state     <= state_n;
      ptr       <= ptr_n;
      hold_cnt  <= hold_cnt_n;
      gnt       <= gnt_n;
      gnt_idx   <= gnt_idx_n;
      gnt_valid <= gnt_valid_n;
    end
  end

endmodule
